// File: rtl/nor_sweep_ctrl_pkg.sv
// Shared types and widths for the gate-block sweep sequencer.
package nor_sweep_pkg;

  localparam int VEC_W   = 4;
  localparam int RES_W   = 3;
  localparam int NUM_VEC = 16;
  localparam int STEP_W  = 4;
  localparam int SIG_W   = 8;
  localparam int HOLD_W  = 8;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_e;

  function automatic logic [VEC_W-1:0] gray_enc(input logic [VEC_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/nor_sweep_ctrl_if.sv
// Control, gate-stimulus and result-readout bundle of the sweep sequencer.
interface nor_sweep_ctrl_if;
  import nor_sweep_pkg::*;

  logic                start;
  logic                gray_mode;
  logic                abort;
  logic [VEC_W-1:0]    drv_vec;
  logic [RES_W-1:0]    gate_out;
  logic                busy;
  logic                done;
  logic                res_valid;
  logic [STEP_W-1:0]   res_idx;
  logic [RES_W-1:0]    res_data;
  logic [STEP_W-1:0]   rd_idx;
  logic [RES_W-1:0]    rd_data;
  logic [SIG_W-1:0]    sig;

  modport slave (
    input  start, gray_mode, abort, gate_out, rd_idx,
    output drv_vec, busy, done, res_valid, res_idx, res_data, rd_data, sig
  );

  modport master (
    output start, gray_mode, abort, gate_out, rd_idx,
    input  drv_vec, busy, done, res_valid, res_idx, res_data, rd_data, sig
  );

endinterface

// File: rtl/nor_sweep_ctrl_sweep_vec_gen.sv
// Step counter with binary or Gray-coded stimulus vector output.
module sweep_vec_gen
  import nor_sweep_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  input  logic              gray,
  output logic [STEP_W-1:0] step,
  output logic [VEC_W-1:0]  vec,
  output logic              last
);

  logic [STEP_W-1:0] step_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_reg <= '0;
    end else if (clr) begin
      step_reg <= '0;
    end else if (inc) begin
      step_reg <= step_reg + 1'b1;
    end
  end

  assign step = step_reg;
  assign vec  = gray ? gray_enc(step_reg) : step_reg;
  assign last = (step_reg == STEP_W'(NUM_VEC - 1));

endmodule

// File: rtl/nor_sweep_ctrl.sv
// Sweeps the gate block through all 16 input vectors and logs each sampled result.
// Optional output signature is built only when NOR_SWEEP_SIG_EN is defined.
module nor_sweep_ctrl
  import nor_sweep_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input logic          clk,
  input logic          rst_n,
  nor_sweep_ctrl_if.slave bus
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  state_e              state_reg, state_next;
  logic [HOLD_W-1:0]   hold_cnt_reg, hold_cnt_next;
  logic                gray_reg;
  logic                clr, inc, wr_en;
  logic [STEP_W-1:0]   step;
  logic                last;
  logic [NUM_VEC-1:0]  wr_sel;
  logic [RES_W-1:0]    result_reg [NUM_VEC];

  sweep_vec_gen u_vec_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (inc),
    .gray  (gray_reg),
    .step  (step),
    .vec   (bus.drv_vec),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      hold_cnt_reg <= '0;
      gray_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      if (clr) begin
        gray_reg <= bus.gray_mode;
      end
    end
  end

  // abort outranks both the hold countdown and the SAMPLE write
  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    clr           = 1'b0;
    inc           = 1'b0;
    wr_en         = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next    = DRIVE;
          hold_cnt_next = '0;
          clr           = 1'b1;
        end
      end
      DRIVE: begin
        if (bus.abort) begin
          state_next = IDLE;
        end else if (hold_cnt_reg == HOLD_LAST) begin
          state_next    = SAMPLE;
          hold_cnt_next = '0;
        end else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      SAMPLE: begin
        if (bus.abort) begin
          state_next = IDLE;
        end else begin
          wr_en = 1'b1;
          if (last) begin
            state_next = DONE;
          end else begin
            inc        = 1'b1;
            state_next = DRIVE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  for (genvar gi = 0; gi < NUM_VEC; gi++) begin : g_wr_sel
    assign wr_sel[gi] = wr_en && (step == STEP_W'(gi));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VEC; i++) result_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_VEC; i++) begin
        if (clr) begin
          result_reg[i] <= '0;
        end else if (wr_sel[i]) begin
          result_reg[i] <= bus.gate_out;
        end
      end
    end
  end

  assign bus.rd_data   = result_reg[bus.rd_idx];
  assign bus.busy      = (state_reg == DRIVE) || (state_reg == SAMPLE);
  assign bus.done      = (state_reg == DONE);
  assign bus.res_valid = wr_en;
  assign bus.res_idx   = wr_en ? step : '0;
  assign bus.res_data  = wr_en ? bus.gate_out : '0;

`ifdef NOR_SWEEP_SIG_EN
  logic [SIG_W-1:0] sig_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_reg <= '0;
    end else if (clr) begin
      sig_reg <= '0;
    end else if (wr_en) begin
      sig_reg <= {sig_reg[SIG_W-2:0], sig_reg[SIG_W-1]} ^ {{(SIG_W-RES_W){1'b0}}, bus.gate_out};
    end
  end

  assign bus.sig = sig_reg;
`else
  assign bus.sig = '0;
`endif

endmodule

// File: tb/tb_nor_sweep_ctrl.sv
// Directed bench for nor_sweep_ctrl: binary/Gray sweeps, abort, start-while-busy, reset mid-sweep.
module tb_nor_sweep_ctrl;
  import nor_sweep_pkg::*;

  localparam int HOLD = 4;
  localparam int PER  = HOLD + 1;
  localparam int INJ_NONE  = 0;
  localparam int INJ_ABORT = 1;
  localparam int INJ_START = 2;
  localparam int INJ_RESET = 3;
  // rotate-XOR signature of a binary sweep, hand-computed from bin_res
  localparam logic [7:0] SIG_BIN = 8'h43;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  nor_sweep_ctrl_if bus ();

  nor_sweep_ctrl #(.HOLD_CYCLES(HOLD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  function automatic logic [2:0] gate_fn(input logic [3:0] v);
    logic a, b, c, d;
    {a, b, c, d} = v;
    return {~(a | b), ~(c | d), ~(a | b | c | d)};
  endfunction

  assign bus.gate_out = gate_fn(bus.drv_vec);

  logic [3:0] gray_seq [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};
  logic [2:0] bin_res  [16] = '{3'd7, 3'd4, 3'd4, 3'd4, 3'd2, 3'd0, 3'd0, 3'd0,
                                3'd2, 3'd0, 3'd0, 3'd0, 3'd2, 3'd0, 3'd0, 3'd0};
  logic [2:0] gray_res [16] = '{3'd7, 3'd4, 3'd4, 3'd4, 3'd0, 3'd0, 3'd0, 3'd2,
                                3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic rd_chk(input int idx, input logic [2:0] exp);
    @(negedge clk);
    bus.rd_idx = 4'(idx);
    #1;
    chk($sformatf("rd_data[%0d]", idx), 32'(bus.rd_data), 32'(exp));
  endtask

  task automatic sig_chk(input string tag);
`ifdef NOR_SWEEP_SIG_EN
    chk(tag, 32'(bus.sig), 32'(SIG_BIN));
`else
    chk(tag, 32'(bus.sig), 32'd0);
`endif
  endtask

  // Starts a sweep and follows it cycle by cycle; cyc 1 is the first DRIVE cycle.
  task automatic sweep(input bit g, input int kind, input int at,
                       output int end_cyc, output bit done_seen);
    logic [3:0] exp_vec;
    logic [3:0] prev_vec;
    int st;
    done_seen = 1'b0;
    prev_vec  = '0;
    end_cyc   = 0;
    @(negedge clk);
    bus.gray_mode = g;
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      end_cyc = cyc;
      if (bus.done) begin
        done_seen = 1'b1;
        break;
      end
      st = (cyc - 1) / PER;
      if (st > 15) break;
      exp_vec = g ? gray_seq[st] : 4'(st);
      chk("drv_vec", 32'(bus.drv_vec), 32'(exp_vec));
      chk("busy", 32'(bus.busy), 32'd1);
      chk("res_valid", 32'(bus.res_valid), 32'((cyc % PER) == 0));
      if ((cyc % PER) == 0) begin
        $display("sample step=%0d vec=%b data=%b", bus.res_idx, bus.drv_vec, bus.res_data);
        chk("res_idx", 32'(bus.res_idx), 32'(st));
        chk("res_data", 32'(bus.res_data), 32'(g ? gray_res[st] : bin_res[st]));
        if (g && st > 0) chk("gray_1bit", 32'($countones(bus.drv_vec ^ prev_vec)), 32'd1);
        prev_vec = bus.drv_vec;
      end
      if (kind == INJ_START && cyc == at) bus.start = 1'b1;
      if (kind == INJ_START && cyc == at + 1) bus.start = 1'b0;
      if (kind == INJ_ABORT && cyc == at) begin
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        break;
      end
      if (kind == INJ_RESET && cyc == at) begin
        rst_n = 1'b0;
        #1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Checks the done pulse: inclusive span from first DRIVE to done is 16*(HOLD+1)+1.
  task automatic finish_chk(input string tag, input int end_cyc, input bit done_seen,
                            input logic [3:0] last_vec);
    chk({tag, "_done_seen"}, 32'(done_seen), 32'd1);
    chk({tag, "_done_cycle"}, 32'(end_cyc), 32'(16 * PER + 1));
    chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk({tag, "_done_1cyc"}, 32'(bus.done), 32'd0);
    chk({tag, "_vec_held"}, 32'(bus.drv_vec), 32'(last_vec));
  endtask

  initial begin
    int  end_cyc;
    bit  done_seen;
    bit  saw_done;

    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.gray_mode = 1'b0;
    bus.rd_idx    = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_drv_vec", 32'(bus.drv_vec), 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_sig", 32'(bus.sig), 32'd0);
    chk("rst_rd_data", 32'(bus.rd_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // binary sweep
    sweep(1'b0, INJ_NONE, 0, end_cyc, done_seen);
    finish_chk("bin", end_cyc, done_seen, 4'd15);
    sig_chk("bin_sig");
    for (int i = 0; i < 16; i++) rd_chk(i, bin_res[i]);
    sig_chk("bin_sig_hold");

    // Gray sweep
    sweep(1'b1, INJ_NONE, 0, end_cyc, done_seen);
    finish_chk("gray", end_cyc, done_seen, 4'd8);
    for (int i = 0; i < 16; i++) rd_chk(i, gray_res[i]);
    rd_chk(3, gate_fn(4'b0010));

    // abort during the step-6 SAMPLE cycle
    sweep(1'b0, INJ_ABORT, 7 * PER, end_cyc, done_seen);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      saw_done = saw_done | bus.done;
    end
    chk("abort_no_done", 32'(saw_done), 32'd0);
    for (int i = 0; i < 16; i++) rd_chk(i, (i < 6) ? bin_res[i] : 3'd0);

    // start pulse during step 3 must not disturb the sweep
    sweep(1'b0, INJ_START, 3 * PER + 2, end_cyc, done_seen);
    finish_chk("busy_start", end_cyc, done_seen, 4'd15);
    sig_chk("second_sig");

    // reset during step 9, then a fresh sweep
    sweep(1'b0, INJ_RESET, 9 * PER + 2, end_cyc, done_seen);
    bus.rd_idx = 4'd0;
    #1;
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_drv_vec", 32'(bus.drv_vec), 32'd0);
    chk("mid_rst_res_idx", 32'(bus.res_idx), 32'd0);
    chk("mid_rst_res_data", 32'(bus.res_data), 32'd0);
    chk("mid_rst_sig", 32'(bus.sig), 32'd0);
    chk("mid_rst_rd_data", 32'(bus.rd_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep(1'b0, INJ_NONE, 0, end_cyc, done_seen);
    finish_chk("post_rst", end_cyc, done_seen, 4'd15);
    sig_chk("post_rst_sig");
    rd_chk(0, bin_res[0]);
    rd_chk(15, bin_res[15]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nor_sweep_ctrl.md
Name: nor_sweep_ctrl

Overview:
Sequencer that drives the 4-input combinational gate block (a,b,c,d -> e,f,g) through all 16 input vectors under clock control.
- Holds each vector for a programmable settle time, then samples the 3 gate outputs.
- Logs each sample into a 16-entry result array readable by index.
- Replaces free-running delay-based stimulus with a synthesizable, restartable sweep usable on the lab board.

Parameters:
HOLD_CYCLES, 4, settle cycles per vector before sampling; legal range 1..255
VEC_W, 4, driven input width (a,b,c,d)
RES_W, 3, sampled output width (e,f,g)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a sweep when idle
gray_mode  in  1  0 = binary order, 1 = Gray-code order; latched at start
abort  in  1  terminates an active sweep
drv_vec  out  VEC_W  gate inputs: [3]=a, [2]=b, [1]=c, [0]=d
gate_out  in  RES_W  gate outputs: [2]=e, [1]=f, [0]=g
busy  out  1  high in DRIVE/SAMPLE
done  out  1  one-cycle pulse after vector 15 is sampled
res_valid  out  1  one-cycle pulse per sample
res_idx  out  4  sweep step index of the current sample
res_data  out  RES_W  sampled gate_out
rd_idx  in  4  result-array read index
rd_data  out  RES_W  result[rd_idx], combinational read
sig  out  8  output signature (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state IDLE; drv_vec=0, busy=0, done=0, res_valid=0, res_idx=0, res_data=0, sig=0; all result entries cleared to 0.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - start=1 -> DRIVE next cycle with step=0 and hold_cnt=0.
  - gray_mode is latched on the same edge.
  - All result entries are cleared on the same edge.
- DRIVE:
  - drv_vec = step (binary) or step^(step>>1) (Gray).
  - hold_cnt increments each cycle.
  - When hold_cnt==HOLD_CYCLES-1 -> SAMPLE.
  - Net effect: DRIVE lasts exactly HOLD_CYCLES cycles.
- SAMPLE (1 cycle):
  - drv_vec held.
  - res_valid=1, res_idx=step, res_data=gate_out.
  - result[step] <= gate_out.
  - If step==15 -> DONE; else step+1, hold_cnt=0 -> DRIVE.
- DONE (1 cycle): done=1, busy=0, drv_vec held at last vector -> IDLE.
- Timing: per vector HOLD_CYCLES+1 cycles; full sweep 16*(HOLD_CYCLES+1)+1 cycles from the first DRIVE cycle to the done pulse.
- start while not IDLE: ignored.
- abort:
  - In DRIVE/SAMPLE: -> IDLE next cycle, no done pulse, no write for an aborted SAMPLE.
  - Entries already written are kept.
  - abort has priority over the SAMPLE write in the same cycle.
  - abort in IDLE/DONE: no effect.
- start and abort together in IDLE: start wins.
- Reset mid-sweep: immediate return to reset values.
- step is 4 bits and never wraps; termination is by the step==15 compare.
- rd_data reflects the array contents the cycle after a write (no bypass).

Optional Feature:
Macro NOR_SWEEP_SIG_EN.
- Defined:
  - 8-bit rotate-XOR signature updates on each SAMPLE write: sig <= {sig[6:0],sig[7]} ^ {5'b0,gate_out}.
  - sig is cleared on start and holds after done.
- Undefined: the sig port exists but is tied to 0 and no signature logic is built.

Decomposition:
- Package nor_sweep_pkg:
  - state enum (IDLE/DRIVE/SAMPLE/DONE)
  - VEC_W, RES_W, NUM_VEC=16
  - SIG_W=8
- Sub-module sweep_vec_gen: step counter plus binary/Gray encode.
  - Ports: clk, rst_n, clr, inc, gray, step, vec, last.
- The FSM, hold counter, result array and signature stay in the top.

Test Plan:
1. Binary order: HOLD_CYCLES=4, gate model e=~(a|b), f=~(c|d), g=~(a|b|c|d); pulse start.
   - drv_vec steps 0..15, each held 4 cycles.
   - res_data at idx0=3'b111, idx1=3'b100, idx4=3'b010, idx15=3'b000.
   - done exactly 81 cycles after the first DRIVE cycle.
2. Gray order: gray_mode=1.
   - drv_vec sequence 0,1,3,2,6,7,5,4,...,8.
   - Exactly one bit changes per step.
   - result[3] holds gate_out for vector 4'b0010.
3. Abort during step 6 SAMPLE:
   - Returns to IDLE next cycle, no done pulse, no write for step 6.
   - result[0..5] valid, result[6..15]=0.
4. start during busy: pulse start at step 3; the sweep is unaffected and done occurs at the nominal cycle.
5. Reset mid-sweep: rst_n low at step 9 -> all outputs 0 immediately; a new start sweeps from step 0.
6. With NOR_SWEEP_SIG_EN defined: complete a binary sweep with the test-1 model; sig equals the reference-model value.
   - A second sweep gives an identical sig.
   - Without the macro, sig stays 0.
